// File: rtl/jpeg_block_sequencer.sv
// Per-8x8-block control sequencer for one HW_JPEGenc channel.
// Optional Huffman watchdog enabled by defining SEQ_TIMEOUT_EN.
module jpeg_block_sequencer #(
  parameter int PIX_PER_BLOCK = 64,
  parameter int DCT_CYCLES    = 8,
  parameter int ZZ_ROWS       = 8,
  parameter int HUFF_TIMEOUT  = 1024
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  input  logic        pix_valid,
  input  logic [7:0]  pix_in,
  output logic        pix_ready,
  output logic        input_1pix_enable,
  output logic [7:0]  pix_1pix_data,
  output logic        dct_enable,
  output logic        dct_end_enable,
  output logic        zigzag_input_enable,
  output logic        zigag_enable,
  output logic [7:0]  matrix_row,
  output logic        Huffman_start,
  input  logic        huff_done,
  output logic        busy,
  output logic        block_done,
  output logic [15:0] block_count,
  output logic        timeout_err
);

  localparam int PW = $clog2(PIX_PER_BLOCK + 1);
  localparam int CW = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_DCT, S_DCT_END, S_ZZ_LOAD,
    S_ZZ_ROW, S_HUFF_START, S_HUFF_WAIT, S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic [7:0] pix_q, pix_d;
  logic       dct_q, dct_d;
  logic       dend_q, dend_d;
  logic       zin_q, zin_d;
  logic       zig_q, zig_d;
  logic [7:0] row_q, row_d;
  logic       hs_q, hs_d;
  logic       bd_q, bd_d;
  logic [15:0] bc_q, bc_d;
  logic       accept;
  logic       skip_inc;

`ifdef SEQ_TIMEOUT_EN
  // tmo marks the block currently in DONE as ended by the watchdog
  logic tmo_q, tmo_d;
  logic terr_q, terr_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q  <= 1'b0;
      terr_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      terr_q <= terr_d;
    end
  end

  assign skip_inc    = tmo_q;
  assign timeout_err = terr_q;
`else
  assign skip_inc    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign accept = pix_valid && (state_q == S_LOAD) && !abort;

  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    cnt_d     = cnt_q;
`ifdef SEQ_TIMEOUT_EN
    tmo_d     = tmo_q;
    terr_d    = terr_q;
`endif
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: begin
        if (accept) begin
          if (pix_cnt_q == PW'(PIX_PER_BLOCK - 1)) begin
            pix_cnt_d = '0;
            cnt_d     = '0;
            state_d   = S_DCT;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      S_DCT: begin
        if (cnt_q == CW'(DCT_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_DCT_END;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DCT_END: state_d = S_ZZ_LOAD;
      S_ZZ_LOAD: begin
        cnt_d   = '0;
        state_d = S_ZZ_ROW;
      end
      S_ZZ_ROW: begin
        if (cnt_q == CW'(ZZ_ROWS - 1)) begin
          cnt_d   = '0;
          state_d = S_HUFF_START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HUFF_START: begin
        cnt_d   = '0;
        state_d = S_HUFF_WAIT;
`ifdef SEQ_TIMEOUT_EN
        tmo_d   = 1'b0;
`endif
      end
      S_HUFF_WAIT: begin
        if (huff_done) begin
          cnt_d   = '0;
          state_d = S_DONE;
`ifdef SEQ_TIMEOUT_EN
        end else if (cnt_q == CW'(HUFF_TIMEOUT - 1)) begin
          cnt_d   = '0;
          tmo_d   = 1'b1;
          terr_d  = 1'b1;
          state_d = S_DONE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: state_d = start ? S_LOAD : S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d   = S_IDLE;
      pix_cnt_d = '0;
      cnt_d     = '0;
`ifdef SEQ_TIMEOUT_EN
      tmo_d     = 1'b0;
      terr_d    = 1'b0;
`endif
    end
  end

  // Moore strobes: registered from the current state, squashed by abort
  always_comb begin
    wr_d   = accept;
    pix_d  = accept ? pix_in : pix_q;
    dct_d  = !abort && (state_q == S_DCT);
    dend_d = !abort && (state_q == S_DCT_END);
    zin_d  = !abort && (state_q == S_ZZ_LOAD);
    zig_d  = !abort && (state_q == S_ZZ_ROW);
    row_d  = zig_d ? cnt_q[7:0] : 8'd0;
    hs_d   = !abort && (state_q == S_HUFF_START);
    bd_d   = !abort && (state_q == S_DONE);
    bc_d   = (bd_d && !skip_inc) ? bc_q + 16'd1 : bc_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pix_cnt_q <= '0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      pix_q     <= 8'd0;
      dct_q     <= 1'b0;
      dend_q    <= 1'b0;
      zin_q     <= 1'b0;
      zig_q     <= 1'b0;
      row_q     <= 8'd0;
      hs_q      <= 1'b0;
      bd_q      <= 1'b0;
      bc_q      <= 16'd0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      pix_q     <= pix_d;
      dct_q     <= dct_d;
      dend_q    <= dend_d;
      zin_q     <= zin_d;
      zig_q     <= zig_d;
      row_q     <= row_d;
      hs_q      <= hs_d;
      bd_q      <= bd_d;
      bc_q      <= bc_d;
    end
  end

  assign pix_ready           = (state_q == S_LOAD);
  assign busy                = (state_q != S_IDLE);
  assign input_1pix_enable   = wr_q;
  assign pix_1pix_data       = pix_q;
  assign dct_enable          = dct_q;
  assign dct_end_enable      = dend_q;
  assign zigzag_input_enable = zin_q;
  assign zigag_enable        = zig_q;
  assign matrix_row          = row_q;
  assign Huffman_start       = hs_q;
  assign block_done          = bd_q;
  assign block_count         = bc_q;

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Self-checking bench for jpeg_block_sequencer.
// Timeline expectations are derived from the phase lengths.
module tb_jpeg_block_sequencer;

  localparam int PIX = 64;
  localparam int DCT = 8;
  localparam int ZR  = 8;
`ifdef SEQ_TIMEOUT_EN
  localparam int HT = 16;
`else
  localparam int HT = 1024;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic pix_valid = 1'b0;
  logic [7:0] pix_in = 8'd0;
  logic huff_done = 1'b0;
  logic pix_ready, input_1pix_enable;
  logic [7:0] pix_1pix_data, matrix_row;
  logic dct_enable, dct_end_enable;
  logic zigzag_input_enable, zigag_enable;
  logic Huffman_start, busy, block_done;
  logic [15:0] block_count;
  logic timeout_err;

  int checks = 0;
  int failures = 0;
  int exp_count = 0;

  jpeg_block_sequencer #(
    .PIX_PER_BLOCK(PIX), .DCT_CYCLES(DCT),
    .ZZ_ROWS(ZR), .HUFF_TIMEOUT(HT)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .start(start), .abort(abort),
    .pix_valid(pix_valid), .pix_in(pix_in),
    .pix_ready(pix_ready),
    .input_1pix_enable(input_1pix_enable),
    .pix_1pix_data(pix_1pix_data),
    .dct_enable(dct_enable),
    .dct_end_enable(dct_end_enable),
    .zigzag_input_enable(zigzag_input_enable),
    .zigag_enable(zigag_enable),
    .matrix_row(matrix_row),
    .Huffman_start(Huffman_start),
    .huff_done(huff_done), .busy(busy),
    .block_done(block_done),
    .block_count(block_count),
    .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=hang expected=finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] strobes();
    return {input_1pix_enable, dct_enable, dct_end_enable,
            zigzag_input_enable, zigag_enable,
            Huffman_start, block_done};
  endfunction

  // k = cycles after the last pixel write appeared
  function automatic logic [6:0] exp_strobe(input int k);
    logic d, e, z, g, h;
    d = (k >= 1) && (k <= DCT);
    e = (k == DCT + 1);
    z = (k == DCT + 2);
    g = (k >= DCT + 3) && (k <= DCT + 2 + ZR);
    h = (k == DCT + ZR + 3);
    return {1'b0, d, e, z, g, h, 1'b0};
  endfunction

  task automatic begin_block();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // mode 0: valid held, data 0..63; 1: toggling; 2: random
  task automatic load_block(input int mode);
    logic [7:0] sent[$];
    logic [7:0] got[$];
    int acc = 0;
    int cyc = 0;
    int bad = 0;
    bit want;
    logic [7:0] v;
    while (acc < PIX) begin
      if (cyc > 2000) begin
        chk("load_bound", acc, PIX);
        break;
      end
      chk("pix_ready_in_load", pix_ready, 1);
      if (input_1pix_enable) got.push_back(pix_1pix_data);
      if (mode == 0) want = 1'b1;
      else if (mode == 1) want = (cyc % 2 == 0);
      else want = ($urandom_range(0, 2) != 0);
      huff_done = 1'($urandom);
      pix_valid = want;
      if (want) begin
        v = (mode == 0) ? 8'(acc) : 8'($urandom);
        pix_in = v;
        sent.push_back(v);
        acc++;
      end
      @(negedge clock);
      cyc++;
    end
    pix_valid = 1'b0;
    huff_done = 1'b0;
    chk("last_write", input_1pix_enable, 1);
    if (input_1pix_enable) got.push_back(pix_1pix_data);
    chk("load_exit", pix_ready, 0);
    chk("write_count", got.size(), PIX);
    foreach (sent[i])
      if (i >= got.size() || got[i] !== sent[i]) bad++;
    chk("pix_data", bad, 0);
  endtask

  task automatic timeline(input int abort_at);
    logic [7:0] er;
    for (int k = 1; k <= DCT + ZR + 3; k++) begin
      @(negedge clock);
      chk("strobes", strobes(), exp_strobe(k));
      er = 8'd0;
      if (k >= DCT + 3 && k <= DCT + 2 + ZR) er = 8'(k - DCT - 3);
      chk("matrix_row", matrix_row, er);
      chk("busy_seq", busy, 1);
      if (k == abort_at) begin
        abort = 1'b1;
        start = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_zig", zigag_enable, 0);
        chk("abort_row", matrix_row, 0);
        chk("abort_count", block_count, exp_count);
        return;
      end
    end
  endtask

  task automatic finish_block(input int w, input bit hold);
    for (int i = 0; i < w; i++) begin
      @(negedge clock);
      chk("wait_quiet", strobes(), 0);
      chk("wait_busy", busy, 1);
    end
    huff_done = 1'b1;
    @(negedge clock);
    huff_done = 1'b0;
    start = hold;
    chk("done_busy", busy, 1);
    @(negedge clock);
    start = 1'b0;
    exp_count = (exp_count + 1) & 16'hFFFF;
    chk("block_done", block_done, 1);
    chk("block_count", block_count, exp_count);
    chk("after_done_busy", busy, hold);
    chk("after_done_ready", pix_ready, hold);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_strobes", {strobes(), busy, pix_ready}, 0);
    chk("rst_data", {pix_1pix_data, matrix_row, block_count}, 0);
    chk("rst_terr", timeout_err, 0);
    reset_n = 1'b1;

    begin_block();
    load_block(0);
    timeline(-1);
    finish_block(5, 1'b0);

    begin_block();
    load_block(1);
    timeline(-1);
    finish_block(2, 1'b0);

    begin_block();
    load_block(2);
    timeline(-1);
    finish_block(3, 1'b1);
    load_block(2);
    timeline(-1);
    finish_block($urandom_range(0, 10), 1'b0);

    begin_block();
    load_block(2);
    timeline(DCT + 3 + 3);
    begin_block();
    load_block(2);
    timeline(-1);
    finish_block(1, 1'b0);

    begin_block();
    load_block(2);
    repeat (3) @(negedge clock);
    chk("pre_rst_dct", dct_enable, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_strobes", {strobes(), busy, pix_ready}, 0);
    chk("async_data", {pix_1pix_data, matrix_row, block_count}, 0);
    exp_count = 0;
    @(negedge clock);
    reset_n = 1'b1;
    begin_block();
    load_block(0);
    timeline(-1);
    finish_block(4, 1'b0);

    begin_block();
    load_block(2);
    timeline(-1);
`ifdef SEQ_TIMEOUT_EN
    for (int i = 1; i <= 17; i++) begin
      @(negedge clock);
      if (i <= 15) begin
        chk("tmo_quiet", block_done, 0);
        chk("tmo_terr_low", timeout_err, 0);
      end
    end
    chk("tmo_done", block_done, 1);
    chk("tmo_terr", timeout_err, 1);
    chk("tmo_count", block_count, exp_count);
    @(negedge clock);
    chk("tmo_idle", busy, 0);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("tmo_clear", timeout_err, 0);
`else
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      chk("hold_busy", busy, 1);
      chk("hold_quiet", strobes(), 0);
      chk("hold_terr", timeout_err, 0);
    end
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("hold_abort_idle", busy, 0);
    chk("hold_abort_count", block_count, exp_count);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jpeg_block_sequencer.md
Name: jpeg_block_sequencer

Overview:
- Generates the per-8x8-block control strobes for one HW_JPEGenc channel instance, replacing the manual bench-driven enables.
- Accepts a pixel stream over a valid/ready handshake and forwards pixels as 1-pixel writes.
- Sequences the DCT, zigzag and Huffman phases in a fixed order, then reports completion and counts finished blocks.

Parameters:
PIX_PER_BLOCK, 64, pixels accepted per block before the DCT phase starts
DCT_CYCLES, 8, cycles dct_enable is held high
ZZ_ROWS, 8, zigzag row sweep length; matrix_row counts 0..ZZ_ROWS-1
HUFF_TIMEOUT, 1024, watchdog limit in cycles for huff_done (used only with SEQ_TIMEOUT_EN)

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  begin a block; sampled in IDLE and DONE
abort  input  1  synchronous return to IDLE from any state
pix_valid  input  1  upstream pixel valid
pix_in  input  8  upstream pixel
pix_ready  output  1  high exactly while in LOAD
input_1pix_enable  output  1  registered pixel-write strobe to datapath
pix_1pix_data  output  8  registered pixel to datapath
dct_enable  output  1  DCT run
dct_end_enable  output  1  DCT end pulse
zigzag_input_enable  output  1  zigzag load pulse
zigag_enable  output  1  zigzag row sweep active
matrix_row  output  8  zigzag row index
Huffman_start  output  1  Huffman start pulse
huff_done  input  1  Huffman stage finished current block
busy  output  1  state is not IDLE
block_done  output  1  1-cycle pulse at end of each block
block_count  output  16  completed blocks; wraps 0xFFFF->0
timeout_err  output  1  sticky watchdog flag (constant 0 without SEQ_TIMEOUT_EN)

Behaviour:
- One clock domain: clock. Reset is asynchronous and active-low on reset_n. On reset: all outputs are 0, state is IDLE, all counters are 0.
- Reset may be asserted mid-operation and always forces IDLE. There is no partial-block recovery.
- All strobe outputs are registered (Moore), so each is valid the cycle after the corresponding state is entered.
- States, each with its transition:
  - IDLE: start=1 -> LOAD.
  - LOAD: pix_ready=1. Each pix_valid&pix_ready makes input_1pix_enable=1 and pix_1pix_data=pix_in on the next cycle, and increments pix_cnt. The accept that makes pix_cnt reach PIX_PER_BLOCK -> DCT. Gaps in pix_valid are allowed.
  - DCT: dct_enable=1 for exactly DCT_CYCLES cycles -> DCT_END.
  - DCT_END: dct_end_enable=1 for 1 cycle -> ZZ_LOAD.
  - ZZ_LOAD: zigzag_input_enable=1 for 1 cycle -> ZZ_ROW.
  - ZZ_ROW: zigag_enable=1; matrix_row=0,1,..,ZZ_ROWS-1 on consecutive cycles -> HUFF_START. matrix_row returns to 0 when leaving this state.
  - HUFF_START: Huffman_start=1 for 1 cycle -> HUFF_WAIT.
  - HUFF_WAIT: huff_done=1 -> DONE. huff_done is ignored in every other state.
  - DONE: block_done=1 for 1 cycle; block_count+1. start=1 -> LOAD (back-to-back, no IDLE cycle); otherwise -> IDLE.
- start is ignored outside IDLE and DONE.
- abort=1 in any state: next state is IDLE, all strobes are 0 next cycle, and pix_cnt and the row counter clear. block_count is unchanged.
- abort and pix_valid in the same cycle: abort wins and the pixel is not accepted. pix_ready is still high that cycle, so upstream must also honour abort.
- abort and start in the same cycle: abort wins.
- No two datapath strobes are ever high in the same cycle, except input_1pix_enable on the cycle after the last LOAD accept (overlaps the first DCT state cycle; dct_enable itself rises one cycle later).
- Minimum block latency, last pixel accepted to Huffman_start high: DCT_CYCLES+ZZ_ROWS+3 cycles (19 with defaults).

Optional Feature:
- Macro: SEQ_TIMEOUT_EN.
- Defined:
  - A watchdog counter runs in HUFF_WAIT. When it reaches HUFF_TIMEOUT without huff_done, the block goes to DONE and block_count is not incremented.
  - block_done still pulses.
  - timeout_err is set and stays set until reset or abort.
- Undefined: no counter; HUFF_WAIT waits indefinitely; timeout_err tied to 0.

Test Plan:
1. Reset, start pulse, 64 pixels 0..63 with pix_valid held high -> input_1pix_enable high 64 cycles carrying 0..63; dct_enable 8 cycles; dct_end_enable, zigzag_input_enable single pulses; matrix_row 0..7; Huffman_start 19 cycles after the last accept. huff_done 5 cycles later -> block_done pulse, block_count=1.
2. pix_valid toggling 1,0,1,0 -> exactly 64 accepts counted, no duplicate writes, LOAD exits only on the 64th accept.
3. start held high through DONE -> second block enters LOAD with no IDLE cycle; block_count=2 after two huff_done pulses; busy never drops.
4. abort during ZZ_ROW at matrix_row=3 -> next cycle IDLE, zigag_enable=0, matrix_row=0, block_count unchanged; a following block completes normally.
5. reset_n low during DCT -> all outputs 0 immediately, without waiting for a clock edge; after release, start begins a clean LOAD with pix_cnt=0.
6. SEQ_TIMEOUT_EN, HUFF_TIMEOUT=16, huff_done held low -> DONE after 16 HUFF_WAIT cycles, timeout_err=1, block_count unchanged. Without the macro -> remains in HUFF_WAIT, timeout_err=0.
